// File: rtl/seq_pkg.sv
// Shared types and default sizes for the serial pattern transmitter.
// The parity option is selected with the SEQ_TX_PARITY_EN macro in the top module.
package seq_pkg;

    localparam int unsigned PAT_W_DEF = 8;
    localparam int unsigned LEN_W_DEF = 4;
    localparam int unsigned REP_W_DEF = 4;
    localparam int unsigned GAP_DEF   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StPar,
        StGap,
        StDone
    } seq_state_e;

    // Counter width able to hold n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Frame request / serial output bundle of the pattern transmitter.
interface seq_pattern_tx_if
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned REP_W = REP_W_DEF
);

    logic             start;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] reps;
    logic             ready;
    logic             dout;
    logic             dout_vld;
    logic             done;

    modport master (
        output start, pat, len, reps,
        input  ready, dout, dout_vld, done
    );

    modport slave (
        input  start, pat, len, reps,
        output ready, dout, dout_vld, done
    );

endinterface

// File: rtl/seq_tx_shifter.sv
// Loadable left-shift register with a remaining-bit counter; msb is the bit on the line.
module seq_tx_shifter #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_val,
    input  logic [LEN_W-1:0] load_cnt,
    output logic             msb,
    output logic             last
);

    logic [PAT_W-1:0] sr_q;
    logic [LEN_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sr_q  <= load_val;
            cnt_q <= load_cnt;
        end else if (shift) begin
            sr_q <= sr_q << 1;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - LEN_W'(1);
            end
        end
    end

    assign msb  = sr_q[PAT_W-1];
    assign last = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends a len-bit window of pat MSB-first, reps times, GAP apart.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after every repetition.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned REP_W = REP_W_DEF,
    parameter int unsigned GAP   = GAP_DEF
) (
    input logic             clk,
    input logic             rst_n,
    seq_pattern_tx_if.slave bus
);

    localparam int unsigned GAP_CW = cnt_width(GAP);

    seq_state_e        state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [GAP_CW-1:0] gap_q, gap_d;
    logic              ready_q, vld_q, done_q;
`ifdef SEQ_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              sh_load, sh_shift, sh_msb, sh_last;
    logic [PAT_W-1:0]  sh_val;
    logic [LEN_W-1:0]  sh_cnt;

    logic [LEN_W-1:0]  len_in;
    logic [PAT_W-1:0]  pat_in;
    seq_state_e        er_state;
    logic              er_reload;

    // Clamp the length and left-align the window so its first bit sits in the MSB.
    always_comb begin
        len_in = (32'(bus.len) > PAT_W) ? LEN_W'(PAT_W) : bus.len;
        pat_in = bus.pat << (LEN_W'(PAT_W) - len_in);
    end

    // Where to go once a repetition (including any parity bit) has been sent.
    always_comb begin
        er_state  = StDone;
        er_reload = 1'b0;
        if (rep_q > REP_W'(1)) begin
            if (GAP > 0) begin
                er_state = StGap;
            end else begin
                er_state  = StShift;
                er_reload = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        rep_d    = rep_q;
        gap_d    = gap_q;
`ifdef SEQ_TX_PARITY_EN
        par_d    = par_q;
`endif
        sh_load  = 1'b1;
        sh_shift = 1'b0;
        sh_val   = '0;
        sh_cnt   = '0;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    pat_d = pat_in;
                    len_d = len_in;
                    rep_d = (bus.reps == '0) ? REP_W'(1) : bus.reps;
`ifdef SEQ_TX_PARITY_EN
                    par_d = ^pat_in;
`endif
                    if (len_in == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StShift;
                        sh_val  = pat_in;
                        sh_cnt  = len_in;
                    end
                end
            end
            StShift: begin
                if (!sh_last) begin
                    sh_load  = 1'b0;
                    sh_shift = 1'b1;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    state_d = StPar;
                    sh_val  = PAT_W'(par_q) << (PAT_W - 1);
`else
                    state_d = er_state;
                    rep_d   = rep_q - REP_W'(1);
                    gap_d   = GAP_CW'(GAP);
                    if (er_reload) begin
                        sh_val = pat_q;
                        sh_cnt = len_q;
                    end
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            StPar: begin
                state_d = er_state;
                rep_d   = rep_q - REP_W'(1);
                gap_d   = GAP_CW'(GAP);
                if (er_reload) begin
                    sh_val = pat_q;
                    sh_cnt = len_q;
                end
            end
`endif
            StGap: begin
                if (gap_q <= GAP_CW'(1)) begin
                    state_d = StShift;
                    sh_val  = pat_q;
                    sh_cnt  = len_q;
                end else begin
                    gap_d = gap_q - GAP_CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the shifter MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pat_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
            ready_q <= 1'b1;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= par_d;
`endif
            ready_q <= (state_d == StIdle) || (state_d == StDone);
            vld_q   <= (state_d == StShift) || (state_d == StPar);
            done_q  <= (state_d == StDone);
        end
    end

    seq_tx_shifter #(
        .PAT_W(PAT_W),
        .LEN_W(LEN_W)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (sh_load),
        .shift   (sh_shift),
        .load_val(sh_val),
        .load_cnt(sh_cnt),
        .msb     (sh_msb),
        .last    (sh_last)
    );

    assign bus.ready    = ready_q;
    assign bus.dout     = sh_msb;
    assign bus.dout_vld = vld_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx; expected streams are written per cycle as '1'/'0' bits,
// '-' idle cycles and 'D' for the done cycle, with parity variants under SEQ_TX_PARITY_EN.
module tb_seq_pattern_tx;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_pattern_tx_if #(.PAT_W(8), .LEN_W(4), .REP_W(4)) bus ();

    seq_pattern_tx #(
        .PAT_W(8),
        .LEN_W(4),
        .REP_W(4),
        .GAP  (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        bus.start = 1'b1;
        bus.pat   = p;
        bus.len   = l;
        bus.reps  = r;
        tick();
        bus.start = 1'b0;
    endtask

    // Sample the current cycle against exp[0], then one cycle per further character.
    task automatic expect_stream(input string tag, input string exp);
        for (int i = 0; i < exp.len(); i++) begin
            byte c;
            c = exp[i];
            if (i > 0) tick();
            if (c == "1" || c == "0") begin
                check_eq($sformatf("%s[%0d] vld", tag, i), 32'(bus.dout_vld), 32'd1);
                check_eq($sformatf("%s[%0d] dout", tag, i), 32'(bus.dout), (c == "1") ? 32'd1 : 32'd0);
                check_eq($sformatf("%s[%0d] ready", tag, i), 32'(bus.ready), 32'd0);
                check_eq($sformatf("%s[%0d] done", tag, i), 32'(bus.done), 32'd0);
            end else if (c == "-") begin
                check_eq($sformatf("%s[%0d] vld", tag, i), 32'(bus.dout_vld), 32'd0);
                check_eq($sformatf("%s[%0d] dout", tag, i), 32'(bus.dout), 32'd0);
                check_eq($sformatf("%s[%0d] ready", tag, i), 32'(bus.ready), 32'd0);
                check_eq($sformatf("%s[%0d] done", tag, i), 32'(bus.done), 32'd0);
            end else begin
                check_eq($sformatf("%s[%0d] done", tag, i), 32'(bus.done), 32'd1);
                check_eq($sformatf("%s[%0d] ready", tag, i), 32'(bus.ready), 32'd1);
                check_eq($sformatf("%s[%0d] vld", tag, i), 32'(bus.dout_vld), 32'd0);
                check_eq($sformatf("%s[%0d] dout", tag, i), 32'(bus.dout), 32'd0);
            end
        end
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, " done"}, 32'(bus.done), 32'd0);
        check_eq({tag, " vld"}, 32'(bus.dout_vld), 32'd0);
        check_eq({tag, " ready"}, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pat   = '0;
        bus.len   = '0;
        bus.reps  = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst ready", 32'(bus.ready), 32'd1);
        check_eq("rst dout", 32'(bus.dout), 32'd0);
        check_eq("rst vld", 32'(bus.dout_vld), 32'd0);
        check_eq("rst done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        tick();
        expect_idle("post_rst");

`ifdef SEQ_TX_PARITY_EN
        send(8'h0D, 4'd4, 4'd1);  expect_stream("f0d", "11011D");
        tick();                   expect_idle("f0d_after");
        send(8'hA5, 4'd8, 4'd2);  expect_stream("fa5", "101001010--101001010D");
        tick();
        send(8'hFF, 4'd0, 4'd3);  expect_stream("len0", "D");
        tick();
        send(8'h3C, 4'd12, 4'd1); expect_stream("len12", "001111000D");
        tick();
        send(8'h06, 4'd3, 4'd0);  expect_stream("reps0", "1100D");
        tick();
        send(8'h02, 4'd2, 4'd3);  expect_stream("reps3", "101--101--101D");
        tick();
        send(8'h0D, 4'd4, 4'd1);  expect_stream("busy_a", "11");
        bus.start = 1'b1; bus.pat = 8'hFF; bus.len = 4'd8;
        tick();
        bus.start = 1'b0;
        expect_stream("busy_b", "011D");
        tick();                   expect_idle("busy_after");
        send(8'h0D, 4'd4, 4'd1);  expect_stream("chain_a", "11011D");
        send(8'h05, 4'd3, 4'd1);  expect_stream("chain_b", "1010D");
`else
        send(8'h0D, 4'd4, 4'd1);  expect_stream("f0d", "1101D");
        tick();                   expect_idle("f0d_after");
        send(8'hA5, 4'd8, 4'd2);  expect_stream("fa5", "10100101--10100101D");
        tick();
        send(8'hFF, 4'd0, 4'd3);  expect_stream("len0", "D");
        tick();
        send(8'h3C, 4'd12, 4'd1); expect_stream("len12", "00111100D");
        tick();
        send(8'h06, 4'd3, 4'd0);  expect_stream("reps0", "110D");
        tick();
        send(8'h02, 4'd2, 4'd3);  expect_stream("reps3", "10--10--10D");
        tick();
        send(8'h0D, 4'd4, 4'd1);  expect_stream("busy_a", "11");
        bus.start = 1'b1; bus.pat = 8'hFF; bus.len = 4'd8;
        tick();
        bus.start = 1'b0;
        expect_stream("busy_b", "01D");
        tick();                   expect_idle("busy_after");
        send(8'h0D, 4'd4, 4'd1);  expect_stream("chain_a", "1101D");
        send(8'h05, 4'd3, 4'd1);  expect_stream("chain_b", "101D");
`endif
        tick();                   expect_idle("chain_after");

        // Asynchronous abort in the middle of bit 3.
        send(8'hA5, 4'd8, 4'd1);  expect_stream("abort_pre", "1010");
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort ready", 32'(bus.ready), 32'd1);
        check_eq("abort dout", 32'(bus.dout), 32'd0);
        check_eq("abort vld", 32'(bus.dout_vld), 32'd0);
        check_eq("abort done", 32'(bus.done), 32'd0);
        tick();
        expect_idle("abort_held");
        rst_n = 1'b1;
        tick();
        expect_idle("abort_release");
`ifdef SEQ_TX_PARITY_EN
        send(8'h0D, 4'd4, 4'd1);  expect_stream("after_abort", "11011D");
`else
        send(8'h0D, 4'd4, 4'd1);  expect_stream("after_abort", "1101D");
`endif
        tick();                   expect_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
